// File: rtl/gpio_ctrl_pkg.sv
// Shared types and register-map helpers for the GPIO access sequencer.
// Covers op codes, FSM states, register selects and lane extraction.
package gpio_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_WRITE  = 3'd1,
    OP_SET    = 3'd2,
    OP_CLEAR  = 3'd3,
    OP_TOGGLE = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
  } state_e;

  localparam logic [2:0] SEL_WR_A  = 3'b000;
  localparam logic [2:0] SEL_DIR_A = 3'b001;
  localparam logic [2:0] SEL_IN_A  = 3'b010;
  localparam logic [2:0] SEL_WR_B  = 3'b011;
  localparam logic [2:0] SEL_DIR_B = 3'b100;

  function automatic logic is_read_only(input logic [2:0] sel);
    return (sel == SEL_IN_A) || (sel > SEL_DIR_B);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_TOGGLE;
  endfunction

  // Input port B is aliased across selects 101..111.
  function automatic logic [7:0] lane_extract(input logic [2:0] sel, input logic [23:0] dout);
    if (sel == SEL_IN_A)     return dout[23:16];
    else if (sel > SEL_DIR_B) return dout[15:8];
    else                      return dout[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants combinationally while enabled, and moves its
// priority pointer only when the granted transaction completes.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             en,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q, last_d;

  // Search starts one past the last completed grant.
  always_comb begin
    int   cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(last_q) + 1 + i) % NREQ;
      if (en && !found && req[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        gnt_idx                = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= IDX_W'(NREQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/gpio_access_ctrl.sv
// Shares the single GPIO register port between NREQ requesters and performs
// set/clear/toggle as atomic read-modify-write sequences.
module gpio_access_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_op,
  input  logic [3*NREQ-1:0]      req_sel,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic [2:0]             gpio_reg_sel,
  output logic                   gpio_we,
  output logic [31:0]            gpio_din,
  input  logic [31:0]            gpio_dout
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;

  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              arb_en, arb_upd;
  logic [DATA_W-1:0] lane_val, wr_val;
  logic [2:0]        new_op, new_sel;
  logic              unused_dout_hi;

  assign unused_dout_hi = ^gpio_dout[31:24];
  assign lane_val       = DATA_W'(lane_extract(sel_q, gpio_dout[23:0]));
  assign arb_en         = (state_q == S_IDLE);
  assign new_op         = req_op[int'(gnt_idx)*3 +: 3];
  assign new_sel        = req_sel[int'(gnt_idx)*3 +: 3];
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (arb_en),
    .upd     (arb_upd),
    .upd_idx (gidx_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    case (op_q)
      OP_SET:    wr_val = old_q | data_q;
      OP_CLEAR:  wr_val = old_q & ~data_q;
      OP_TOGGLE: wr_val = old_q ^ data_q;
      default:   wr_val = data_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sel_d        = sel_q;
    data_d       = data_q;
    old_d        = old_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    gidx_d       = gidx_q;
    req_ready    = '0;
    rsp_valid    = '0;
    gpio_reg_sel = 3'b000;
    gpio_we      = 1'b0;
    gpio_din     = 32'h0;
    arb_upd      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gate with reset so nothing looks accepted while reset is held.
        req_ready = reset ? gnt : '0;
        if (|gnt) begin
          op_d   = new_op;
          sel_d  = new_sel;
          data_d = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          gidx_d = gnt_idx;
          if (!op_legal(new_op) || (new_op != OP_READ && is_read_only(new_sel))) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RSP;
          end else if (new_op == OP_WRITE) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        gpio_reg_sel = sel_q;
        old_d        = lane_val;
        if (op_q == OP_READ) begin
          rsp_data_d = lane_val;
          rsp_err_d  = 1'b0;
          state_d    = S_RSP;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        gpio_reg_sel = sel_q;
        gpio_we      = 1'b1;
        gpio_din     = 32'(wr_val);
        rsp_data_d   = (op_q == OP_WRITE) ? data_q : old_q;
        rsp_err_d    = 1'b0;
        state_d      = S_RSP;
      end
      S_RSP: begin
        rsp_valid[gidx_q] = 1'b1;
        if (rsp_ready[gidx_q]) begin
          arb_upd = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      sel_q      <= 3'b000;
      data_q     <= '0;
      old_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      gidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      old_q      <= old_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      gidx_q     <= gidx_d;
    end
  end

endmodule

// File: tb/tb_gpio_access_ctrl.sv
// Directed bench for gpio_access_ctrl with a small behavioural GPIO register block.
module tb_gpio_access_ctrl;

  localparam int NREQ   = 2;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3*NREQ-1:0]      req_op, req_sel;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;
  logic [2:0]             gpio_reg_sel;
  logic                   gpio_we;
  logic [31:0]            gpio_din, gpio_dout;

  logic [7:0]  wr_a = 8'h00, dir_a = 8'h00, wr_b = 8'h00, dir_b = 8'h00;
  logic [7:0]  in_a = 8'h00, in_b = 8'h00, lane0;
  int          we_cnt = 0;
  logic [31:0] last_din = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_access_ctrl #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_sel      (req_sel),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .gpio_reg_sel (gpio_reg_sel),
    .gpio_we      (gpio_we),
    .gpio_din     (gpio_din),
    .gpio_dout    (gpio_dout)
  );

  always_comb begin
    case (gpio_reg_sel)
      3'b000:  lane0 = wr_a;
      3'b001:  lane0 = dir_a;
      3'b011:  lane0 = wr_b;
      3'b100:  lane0 = dir_b;
      default: lane0 = 8'h00;
    endcase
    gpio_dout = {8'h00, in_a, in_b, lane0};
  end

  always @(posedge clk) begin
    if (gpio_we) begin
      case (gpio_reg_sel)
        3'b000:  wr_a  <= gpio_din[7:0];
        3'b001:  dir_a <= gpio_din[7:0];
        3'b011:  wr_b  <= gpio_din[7:0];
        3'b100:  dir_b <= gpio_din[7:0];
        default: ;
      endcase
      we_cnt   <= we_cnt + 1;
      last_din <= gpio_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns latency in cycles
  // counted from the accept cycle (99 on timeout).
  task automatic issue(input int r, input logic [2:0] op, input logic [2:0] sel,
                       input logic [7:0] data, output int lat,
                       output logic [7:0] rdata, output logic rerr);
    bit got;
    got = 0;
    lat = 99;
    rdata = 8'h00;
    rerr = 1'b0;
    req_op[r*3 +: 3]            = op;
    req_sel[r*3 +: 3]           = sel;
    req_data[r*DATA_W +: DATA_W] = data;
    req_valid[r]                 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready[r]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    if (got) begin
      lat = 1;
      while (!rsp_valid[r] && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (!rsp_valid[r]) lat = 99;
      rdata        = rsp_data;
      rerr         = rsp_err;
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
    end
  endtask

  initial begin
    int          lat, w0, hold_ok, got;
    logic [7:0]  rd;
    logic        er;
    logic [1:0]  g, exp_g;

    reset     = 1'b0;
    req_valid = 2'b01;
    rsp_ready = '0;
    req_op    = '0;
    req_sel   = '0;
    req_data  = '0;

    // Reset state, with a request pending that must not be acknowledged.
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_gpio_we",   32'(gpio_we),   32'h0);
    chk("rst_gpio_sel",  32'(gpio_reg_sel), 32'h0);
    chk("rst_gpio_din",  gpio_din,       32'h0);
    repeat (3) @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;

    // Plain write.
    w0 = we_cnt;
    issue(0, 3'd1, 3'b000, 8'hA5, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rsp_data", 32'(rd), 32'hA5);
    chk("wr_rsp_err", 32'(er), 32'h0);
    chk("wr_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wr_din", last_din, 32'h0000_00A5);
    chk("wr_reg", 32'(wr_a), 32'hA5);

    // Read-modify-write sequence on WR_A.
    issue(0, 3'd1, 3'b000, 8'hF0, lat, rd, er);
    w0 = we_cnt;
    issue(1, 3'd2, 3'b000, 8'h0F, lat, rd, er);
    chk("set_latency", 32'(lat), 32'd3);
    chk("set_rsp_old", 32'(rd), 32'hF0);
    chk("set_reg", 32'(wr_a), 32'hFF);
    chk("set_we_pulses", 32'(we_cnt - w0), 32'd1);
    issue(1, 3'd3, 3'b000, 8'h81, lat, rd, er);
    chk("clr_rsp_old", 32'(rd), 32'hFF);
    chk("clr_reg", 32'(wr_a), 32'h7E);
    issue(1, 3'd4, 3'b000, 8'hFF, lat, rd, er);
    chk("tog_rsp_old", 32'(rd), 32'h7E);
    chk("tog_reg", 32'(wr_a), 32'h81);
    chk("tog_din", last_din, 32'h0000_0081);

    // Reads of the input lanes.
    in_a = 8'h3C;
    in_b = 8'hC3;
    w0 = we_cnt;
    issue(0, 3'd0, 3'b010, 8'h00, lat, rd, er);
    chk("rd_ina_latency", 32'(lat), 32'd2);
    chk("rd_ina_data", 32'(rd), 32'h3C);
    issue(1, 3'd0, 3'b110, 8'h00, lat, rd, er);
    chk("rd_inb_data", 32'(rd), 32'hC3);
    chk("rd_inb_err", 32'(er), 32'h0);
    chk("rd_no_we", 32'(we_cnt - w0), 32'd0);

    // Error responses; the last one comes from requester 1.
    w0 = we_cnt;
    issue(0, 3'd2, 3'b010, 8'hFF, lat, rd, er);
    chk("ro_err_latency", 32'(lat), 32'd1);
    chk("ro_err_flag", 32'(er), 32'h1);
    chk("ro_err_data", 32'(rd), 32'h0);
    issue(1, 3'd6, 3'b000, 8'h55, lat, rd, er);
    chk("ill_err_latency", 32'(lat), 32'd1);
    chk("ill_err_flag", 32'(er), 32'h1);
    chk("ill_err_data", 32'(rd), 32'h0);
    chk("err_no_we", 32'(we_cnt - w0), 32'd0);
    chk("err_reg_kept", 32'(wr_a), 32'h81);

    // Both requesters pending: strict alternation, plus back-pressure.
    req_op    = {3'd1, 3'd1};
    req_sel   = {3'b001, 3'b011};
    req_data  = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      got = 0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (|req_ready) begin
          got = 1;
          break;
        end
        @(negedge clk);
      end
      g = req_ready;
      chk("rr_grant", 32'(g), 32'(exp_g));
      @(negedge clk);
      for (int n = 0; n < 20 && !(|rsp_valid); n++) @(negedge clk);
      chk("rr_rsp_owner", 32'(rsp_valid), 32'(exp_g));
      if (k == 0) begin
        hold_ok = 1;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (rsp_valid !== 2'b01 || req_ready !== 2'b00) hold_ok = 0;
        end
        chk("hold_rsp_stable", 32'(hold_ok), 32'd1);
      end
      rsp_ready = g;
      @(negedge clk);
      rsp_ready = '0;
    end
    req_valid = '0;
    chk("rr_wr_b", 32'(wr_b), 32'h11);
    chk("rr_dir_a", 32'(dir_a), 32'h22);

    // Requester 0 completes last, so requester 1 would be next without reset.
    issue(0, 3'd0, 3'b000, 8'h00, lat, rd, er);
    chk("pre_rst_read", 32'(rd), 32'h81);

    // Reset in the middle of a read-modify-write.
    w0 = we_cnt;
    req_op[2:0]   = 3'd2;
    req_sel[2:0]  = 3'b011;
    req_data[7:0] = 8'h0F;
    req_valid     = 2'b01;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready[0]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_accept", 32'(got), 32'd1);
    @(negedge clk);
    req_valid = '0;
    chk("mid_rd_we", 32'(gpio_we), 32'h0);
    @(negedge clk);
    chk("mid_wr_we", 32'(gpio_we), 32'h1);
    chk("mid_wr_din", gpio_din, 32'h0000_001F);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(gpio_we), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_din", gpio_din, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_no_write", 32'(we_cnt - w0), 32'd0);
    chk("abort_reg_kept", 32'(wr_b), 32'h11);
    req_op    = '0;
    req_valid = 2'b11;
    reset     = 1'b1;
    #1;
    chk("post_rst_prio", 32'(req_ready), 32'h1);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
